imem_responder: RTL and testbench

//  Instruction-side responder for the RV64I pipeline core. Each fetch takes the

---
 rtl/imem_responder.sv | 192 +++++++++++++++++++
 tb/tb_imem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-side responder for the RV64I pipeline core. Every fetch
//   request (the reset PC while booting, otherwise the core's next PC) is
//   looked up in a local instruction ROM. The registered pc/instruction pair
//   is then presented back to the core after an optional number of bubble
//   cycles. A halt-class exception stops fetching until reset. A cycle
//   counter runs while the block is not halted. The ROM is loaded through a
//   program port that stays live in every state, reset included.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous reset, active-high
//   new_pc_i       core's requested next PC
//   exceptions_i   core exception vector {EBREAK, ECALL, Decode, Fetch}
//   prog_we_i      ROM write strobe
//   prog_addr_i    ROM word address to write
//   prog_data_i    ROM write data
//   pc_o           PC of the presented instruction
//   data_o         presented instruction (NOP while bubbling or halted)
//   valid_o        data_o is a real fetch response
//   fetch_fault_o  presented fetch was misaligned or outside the ROM window
//   halt_o         sticky, fetching has stopped
//   halt_cause_o   exception vector that caused the halt
//   cycle_cnt_o    non-halted cycles since reset
module imem_responder #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    INST_WIDTH  = 32,
  parameter int                    ROM_AW      = 12,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = DATA_WIDTH'(64'h8000_0000),
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(64'h8000_0000),
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [3:0]            HALT_MASK   = 4'b1111
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] new_pc_i,
  input  logic [3:0]            exceptions_i,
  input  logic                  prog_we_i,
  input  logic [ROM_AW-1:0]     prog_addr_i,
  input  logic [INST_WIDTH-1:0] prog_data_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [INST_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  fetch_fault_o,
  output logic                  halt_o,
  output logic [3:0]            halt_cause_o,
  output logic [63:0]           cycle_cnt_o
);

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_WAIT, ST_HALT} state_t;

  state_t                state_q, state_n;
  logic [DATA_WIDTH-1:0] req_q, req_n;
  logic [3:0]            wcnt_q, wcnt_n;

  logic [DATA_WIDTH-1:0] pc_n;
  logic [INST_WIDTH-1:0] data_n;
  logic                  valid_n, fault_n, halt_n;
  logic [3:0]            cause_n;

  logic [INST_WIDTH-1:0] rom [2**ROM_AW];

  logic [DATA_WIDTH-1:0] fetch_req;
  logic [DATA_WIDTH-1:0] lookup_addr;
  logic [DATA_WIDTH-1:0] word_off;
  logic                  lookup_fault;
  logic [INST_WIDTH-1:0] rom_word;
  logic                  halt_event;

  // While booting the core has not produced a PC yet, so the reset vector is
  // fetched. While waiting, the latched request is the one being answered.
  assign fetch_req   = (state_q == ST_BOOT) ? RESET_PC : new_pc_i;
  assign lookup_addr = (state_q == ST_WAIT) ? req_q : fetch_req;

  // Word offset from the ROM base. Any set bit above the ROM index width
  // means the address lies beyond the ROM. An address below the base wraps
  // to a huge offset, but it is flagged explicitly so that the check does
  // not depend on that wrap.
  assign word_off     = (lookup_addr - BASE_ADDR) >> 2;
  assign lookup_fault = (lookup_addr[1:0] != 2'b00) ||
                        (lookup_addr < BASE_ADDR) ||
                        (word_off[DATA_WIDTH-1:ROM_AW] != '0);
  assign rom_word     = rom[word_off[ROM_AW-1:0]];

  assign halt_event = ((exceptions_i & HALT_MASK) != 4'b0000) && (state_q != ST_HALT);

  // Program port. The ROM read above is sampled at the same edge, so a
  // fetch colliding with a write to the same word still sees the old word.
  always_ff @(posedge clk_i) begin
    if (prog_we_i) begin
      rom[prog_addr_i] <= prog_data_i;
    end
  end

  // Next-state and next-output logic. Every register holds by default. A
  // halt event overrides whatever fetch or wait completion would otherwise
  // happen at the same edge.
  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    wcnt_n  = wcnt_q;
    pc_n    = pc_o;
    data_n  = data_o;
    valid_n = valid_o;
    fault_n = fetch_fault_o;
    halt_n  = halt_o;
    cause_n = halt_cause_o;

    if (halt_event) begin
      state_n = ST_HALT;
      halt_n  = 1'b1;
      cause_n = exceptions_i;
      data_n  = NOP;
      valid_n = 1'b0;
      fault_n = 1'b0;
    end else begin
      case (state_q)
        ST_BOOT, ST_FETCH: begin
          if (WAIT_CYCLES == 0) begin
            state_n = ST_FETCH;
            pc_n    = lookup_addr;
            data_n  = lookup_fault ? '0 : rom_word;
            valid_n = 1'b1;
            fault_n = lookup_fault;
          end else begin
            state_n = ST_WAIT;
            req_n   = fetch_req;
            wcnt_n  = 4'(WAIT_CYCLES);
            pc_n    = fetch_req;
            data_n  = NOP;
            valid_n = 1'b0;
            fault_n = 1'b0;
          end
        end
        ST_WAIT: begin
          // The response goes out on the edge where the count reaches zero.
          if (wcnt_q == 4'd1) begin
            state_n = ST_FETCH;
            wcnt_n  = 4'd0;
            pc_n    = lookup_addr;
            data_n  = lookup_fault ? '0 : rom_word;
            valid_n = 1'b1;
            fault_n = lookup_fault;
          end else begin
            wcnt_n = wcnt_q - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers. Reset wins over everything, including a
  // wait in progress, but leaves the ROM contents alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_BOOT;
      req_q         <= RESET_PC;
      wcnt_q        <= 4'd0;
      pc_o          <= RESET_PC;
      data_o        <= NOP;
      valid_o       <= 1'b0;
      fetch_fault_o <= 1'b0;
      halt_o        <= 1'b0;
      halt_cause_o  <= 4'b0000;
    end else begin
      state_q       <= state_n;
      req_q         <= req_n;
      wcnt_q        <= wcnt_n;
      pc_o          <= pc_n;
      data_o        <= data_n;
      valid_o       <= valid_n;
      fetch_fault_o <= fault_n;
      halt_o        <= halt_n;
      halt_cause_o  <= cause_n;
    end
  end

  // The cycle counter also advances on the halting edge, because the state
  // is not yet HALT at that edge. Once halted it freezes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_o <= 64'd0;
    end else if (state_q != ST_HALT) begin
      cycle_cnt_o <= cycle_cnt_o + 64'd1;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//   Self-checking bench for imem_responder. Instance dut_a uses zero wait
//   states and instance dut_b uses two. Both share the clock, the reset and
//   the program port, so they hold identical ROM contents. Coverage:
//   - a vector table for boot, sequential fetch and address faults
//   - hand-written sequences for wait states, halt, and a program/fetch
//     collision
//   - randomized traffic on dut_a checked against a transaction-level model
module tb_imem_responder;

  localparam logic [63:0] BASE      = 64'h8000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          ROM_WORDS = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] new_pc_a, new_pc_b;
  logic [3:0]  exc_a, exc_b;
  logic        prog_we;
  logic [11:0] prog_addr;
  logic [31:0] prog_data;

  logic [63:0] pc_a, pc_b, cnt_a, cnt_b;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b, fault_a, fault_b, halt_a, halt_b;
  logic [3:0]  cause_a, cause_b;

  imem_responder dut_a (
    .clk_i(clk), .rst_i(rst), .new_pc_i(new_pc_a), .exceptions_i(exc_a),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
    .pc_o(pc_a), .data_o(data_a), .valid_o(valid_a), .fetch_fault_o(fault_a),
    .halt_o(halt_a), .halt_cause_o(cause_a), .cycle_cnt_o(cnt_a)
  );

  imem_responder #(.WAIT_CYCLES(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .new_pc_i(new_pc_b), .exceptions_i(exc_b),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
    .pc_o(pc_b), .data_o(data_b), .valid_o(valid_b), .fetch_fault_o(fault_b),
    .halt_o(halt_b), .halt_cause_o(cause_b), .cycle_cnt_o(cnt_b)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference-model state: what dut_a should present after each edge.
  logic [31:0] mRom [0:63];
  logic        mBoot, mHalted, mValid, mFault;
  logic [63:0] mCnt, mPc;
  logic [31:0] mData;
  logic [3:0]  mCause;

  typedef struct {
    logic [63:0] pcIn;
    logic [63:0] expPc;
    logic [31:0] expData;
    logic        expValid;
    logic        expFault;
    logic [63:0] expCnt;
  } vec_t;

  vec_t vecs [8];

  // Word 0 is the instruction the boot check looks for. The other words are
  // distinct patterns, so that a wrong index shows up as a wrong value.
  function automatic logic [31:0] romWord(input int i);
    if (i == 0) return 32'h0010_0093;
    return 32'hA000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  // Returns {fault, data} for a fetch of address a, using the ROM as it
  // stood before the edge.
  function automatic logic [32:0] lookup(input logic [63:0] a);
    logic [63:0] idx;
    if (a[1:0] != 2'b00 || a < BASE || a >= BASE + 64'(4 * ROM_WORDS))
      return {1'b1, 32'h0};
    idx = (a - BASE) / 64'd4;
    return {1'b0, mRom[idx[5:0]]};
  endfunction

  // Advances the model by one clock edge, given the inputs at that edge.
  task automatic modelStep(input logic r, input logic [63:0] pc, input logic [3:0] e,
                           input logic we, input logic [11:0] wa, input logic [31:0] wd);
    logic [32:0] res;
    logic [63:0] req;
    if (r) begin
      mBoot = 1'b1; mHalted = 1'b0; mCnt = 64'd0; mCause = 4'd0;
      mPc = BASE; mData = NOP; mValid = 1'b0; mFault = 1'b0;
    end else if (!mHalted) begin
      mCnt = mCnt + 64'd1;
      if (e != 4'd0) begin
        mHalted = 1'b1; mCause = e; mData = NOP; mValid = 1'b0; mFault = 1'b0;
      end else begin
        req   = mBoot ? BASE : pc;
        mBoot = 1'b0;
        res   = lookup(req);
        mPc = req; mData = res[31:0]; mFault = res[32]; mValid = 1'b1;
      end
    end
    if (we) mRom[wa[5:0]] = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives dut_a's fetch, exception and program inputs, then lets one edge pass.
  task automatic applyStimulus(input logic [63:0] pc, input logic [3:0] e,
                               input logic we, input logic [11:0] wa, input logic [31:0] wd);
    new_pc_a  = pc;
    exc_a     = e;
    prog_we   = we;
    prog_addr = wa;
    prog_data = wd;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkA(input string tag, input logic [63:0] pc, input logic [31:0] data,
                        input logic valid, input logic fault, input logic halt,
                        input logic [3:0] cause, input logic [63:0] cnt);
    checkOutput({tag, ".a.pc"},    pc_a,    pc);
    checkOutput({tag, ".a.data"},  64'(data_a), 64'(data));
    checkOutput({tag, ".a.valid"}, 64'(valid_a), 64'(valid));
    checkOutput({tag, ".a.fault"}, 64'(fault_a), 64'(fault));
    checkOutput({tag, ".a.halt"},  64'(halt_a),  64'(halt));
    checkOutput({tag, ".a.cause"}, 64'(cause_a), 64'(cause));
    checkOutput({tag, ".a.cnt"},   cnt_a,   cnt);
  endtask

  task automatic checkB(input string tag, input logic [63:0] pc, input logic [31:0] data,
                        input logic valid, input logic fault, input logic [63:0] cnt);
    checkOutput({tag, ".b.pc"},    pc_b,    pc);
    checkOutput({tag, ".b.data"},  64'(data_b), 64'(data));
    checkOutput({tag, ".b.valid"}, 64'(valid_b), 64'(valid));
    checkOutput({tag, ".b.fault"}, 64'(fault_b), 64'(fault));
    checkOutput({tag, ".b.halt"},  64'(halt_b),  64'd0);
    checkOutput({tag, ".b.cnt"},   cnt_b,   cnt);
  endtask

  logic        rRst, rWe;
  logic [63:0] rPc;
  logic [3:0]  rExc;
  logic [11:0] rWa;
  logic [31:0] rWd;

  initial begin
    rst = 1'b1;
    new_pc_a = '0; new_pc_b = '0; exc_a = '0; exc_b = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // Load words 0..63 while reset is held; the program port stays live in reset.
    for (int i = 0; i < 64; i++) begin
      applyStimulus(64'd0, 4'd0, 1'b1, 12'(i), romWord(i));
      mRom[i] = romWord(i);
    end
    applyStimulus(64'd0, 4'd0, 1'b0, 12'd0, 32'd0);
    checkA("reset", BASE, NOP, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0);
    checkB("reset", BASE, NOP, 1'b0, 1'b0, 64'd0);

    // Boot, sequential fetch and address faults, one edge per vector.
    vecs[0] = '{BASE + 64'h40,      BASE,               romWord(0),  1'b1, 1'b0, 64'd1};
    vecs[1] = '{BASE + 64'h4,       BASE + 64'h4,       romWord(1),  1'b1, 1'b0, 64'd2};
    vecs[2] = '{BASE + 64'h8,       BASE + 64'h8,       romWord(2),  1'b1, 1'b0, 64'd3};
    vecs[3] = '{BASE + 64'h2,       BASE + 64'h2,       32'h0,       1'b1, 1'b1, 64'd4};
    vecs[4] = '{64'h7FFF_FFFC,      64'h7FFF_FFFC,      32'h0,       1'b1, 1'b1, 64'd5};
    vecs[5] = '{BASE + 64'h4000,    BASE + 64'h4000,    32'h0,       1'b1, 1'b1, 64'd6};
    vecs[6] = '{BASE + 64'hFC,      BASE + 64'hFC,      romWord(63), 1'b1, 1'b0, 64'd7};
    vecs[7] = '{64'h0,              64'h0,              32'h0,       1'b1, 1'b1, 64'd8};
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].pcIn, 4'd0, 1'b0, 12'd0, 32'd0);
      checkA($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expData, vecs[i].expValid,
             vecs[i].expFault, 1'b0, 4'd0, vecs[i].expCnt);
    end

    // Two bubble cycles precede each response on dut_b, and new_pc_i is ignored while waiting.
    rst = 1'b1; tick(); rst = 1'b0;
    new_pc_b = BASE + 64'h10;
    tick(); checkB("w_boot0", BASE, NOP, 1'b0, 1'b0, 64'd1);
    tick(); checkB("w_boot1", BASE, NOP, 1'b0, 1'b0, 64'd2);
    tick(); checkB("w_boot2", BASE, romWord(0), 1'b1, 1'b0, 64'd3);
    tick(); checkB("w_req0", BASE + 64'h10, NOP, 1'b0, 1'b0, 64'd4);
    new_pc_b = BASE + 64'h20;
    tick(); checkB("w_req1", BASE + 64'h10, NOP, 1'b0, 1'b0, 64'd5);
    tick(); checkB("w_resp", BASE + 64'h10, romWord(4), 1'b1, 1'b0, 64'd6);
    tick(); checkB("w_next", BASE + 64'h20, NOP, 1'b0, 1'b0, 64'd7);
    rst = 1'b1;
    tick(); checkB("w_rstmid", BASE, NOP, 1'b0, 1'b0, 64'd0);
    rst = 1'b0;

    // Randomized traffic on dut_a against the model. Writes go to words
    // 32..63 only, so words 0..31 keep their loaded values for later checks.
    for (int i = 0; i < 400; i++) begin
      rRst = (i == 0) || (mHalted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 9))
        0:       rPc = BASE + 64'(4 * $urandom_range(0, 63)) + 64'($urandom_range(1, 3));
        1:       rPc = BASE - 64'(4 * $urandom_range(1, 100));
        2:       rPc = BASE + 64'(4 * ROM_WORDS) + 64'(4 * $urandom_range(0, 100));
        default: rPc = BASE + 64'(4 * $urandom_range(0, 63));
      endcase
      rExc = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      rWe  = ($urandom_range(0, 3) == 0);
      rWa  = 12'(32 + $urandom_range(0, 31));
      rWd  = $urandom;
      rst  = rRst;
      modelStep(rRst, rPc, rExc, rWe, rWa, rWd);
      applyStimulus(rPc, rExc, rWe, rWa, rWd);
      checkA($sformatf("rnd%0d", i), mPc, mData, mValid, mFault, mHalted, mCause, mCnt);
    end
    rst = 1'b0;

    // Halt: an EBREAK stops fetching, the cause is sticky and the counter freezes.
    rst = 1'b1; applyStimulus(64'd0, 4'd0, 1'b0, 12'd0, 32'd0); rst = 1'b0;
    applyStimulus(BASE + 64'h40, 4'd0, 1'b0, 12'd0, 32'd0);
    checkA("h_boot", BASE, romWord(0), 1'b1, 1'b0, 1'b0, 4'd0, 64'd1);
    applyStimulus(BASE + 64'h4, 4'd0, 1'b0, 12'd0, 32'd0);
    checkA("h_fetch", BASE + 64'h4, romWord(1), 1'b1, 1'b0, 1'b0, 4'd0, 64'd2);
    applyStimulus(BASE + 64'h8, 4'b1000, 1'b0, 12'd0, 32'd0);
    checkA("h_halt", BASE + 64'h4, NOP, 1'b0, 1'b0, 1'b1, 4'b1000, 64'd3);
    applyStimulus(BASE + 64'hC, 4'b0010, 1'b0, 12'd0, 32'd0);
    checkA("h_sticky", BASE + 64'h4, NOP, 1'b0, 1'b0, 1'b1, 4'b1000, 64'd3);
    applyStimulus(BASE + 64'h10, 4'd0, 1'b0, 12'd0, 32'd0);
    checkA("h_frozen", BASE + 64'h4, NOP, 1'b0, 1'b0, 1'b1, 4'b1000, 64'd3);
    rst = 1'b1;
    applyStimulus(BASE + 64'h10, 4'd0, 1'b0, 12'd0, 32'd0);
    checkA("h_reset", BASE, NOP, 1'b0, 1'b0, 1'b0, 4'd0, 64'd0);
    rst = 1'b0;
    applyStimulus(BASE + 64'h10, 4'd0, 1'b0, 12'd0, 32'd0);
    checkA("h_reboot", BASE, romWord(0), 1'b1, 1'b0, 1'b0, 4'd0, 64'd1);

    // Collision: a write to the word being fetched at the same edge returns the old word.
    applyStimulus(BASE + 64'h10, 4'd0, 1'b1, 12'd4, 32'hDEAD_BEEF);
    checkA("c_old", BASE + 64'h10, romWord(4), 1'b1, 1'b0, 1'b0, 4'd0, 64'd2);
    applyStimulus(BASE + 64'h10, 4'd0, 1'b0, 12'd0, 32'd0);
    checkA("c_new", BASE + 64'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 4'd0, 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
